// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller.
//   R_DEF  : default counter / duty width
//   DW_DEF : default period-divider width
//   state_t: ramp FSM states
package pwm_pkg;

  localparam int unsigned R_DEF  = 9;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_core.sv
// PWM counter and comparator.
//   clk        : clock
//   reset      : synchronous active-high reset
//   enable     : run the counter; low holds it at 0 and forces pwm_out low
//   duty       : compare value
//   pwm_out    : registered PWM waveform, high while duty > cnt
//   period_end : high in the last cycle of each running period
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned R = R_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [R-1:0] duty,
  output logic         pwm_out,
  output logic         period_end
);

  localparam logic [R-1:0] CNT_MAX = '1;

  logic [R-1:0] cnt;

  // Free-running counter, wraps naturally at 2^R-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + R'(1);
      pwm_out <= (duty > cnt);
    end
  end

  assign period_end = enable && (cnt == CNT_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty ramps toward an accepted target.
//   clk, reset : clock, synchronous active-high reset
//   enable     : run PWM and ramp; low pauses both
//   tgt_duty   : requested final duty
//   tgt_valid  : target offered; tgt_ready : accepted when both high
//   step       : duty increment per update (0 behaves as 1)
//   period_div : update every period_div+1 PWM periods
//   duty_cur   : duty applied to the comparator
//   pwm_out    : registered PWM waveform
//   busy       : ramp in progress
//   done       : one-cycle pulse when duty_cur reaches the target
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned R  = R_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [R-1:0]  tgt_duty,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [R-1:0]  step,
  input  logic [DW-1:0] period_div,
  output logic [R-1:0]  duty_cur,
  output logic          pwm_out,
  output logic          busy,
  output logic          done
);

  state_t        state_q, state_d;
  logic [R-1:0]  tgt_q, tgt_d;
  logic [R-1:0]  step_q, step_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [R-1:0]  duty_d;
  logic          done_d;
  logic          period_end;

  // Ramp arithmetic one bit wider so neither direction can wrap.
  logic [R:0]    tgt_x, duty_x, step_x, diff_x, moved_x;
  logic          up;
  logic [R-1:0]  ramp_duty;

  pwm_core #(.R(R)) u_core (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .duty       (duty_cur),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  // Next duty value one step closer to the latched target.
  always_comb begin
    tgt_x   = {1'b0, tgt_q};
    duty_x  = {1'b0, duty_cur};
    step_x  = {1'b0, step_q};
    up      = (tgt_x >= duty_x);
    diff_x  = up ? (tgt_x - duty_x) : (duty_x - tgt_x);
    moved_x = up ? (duty_x + step_x) : (duty_x - step_x);
    ramp_duty = (diff_x <= step_x) ? tgt_q : R'(moved_x);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      step_q    <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      duty_cur  <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      duty_cur  <= duty_d;
      done      <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    duty_d    = duty_cur;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d     = tgt_duty;
          step_d    = (step == '0) ? R'(1) : step;
          div_d     = period_div;
          div_cnt_d = '0;
          if (tgt_duty == duty_cur) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        // period_end is gated by enable, so a paused ramp freezes here.
        if (period_end) begin
          if (div_cnt_q == div_q) begin
            div_cnt_d = '0;
            duty_d    = ramp_duty;
            if (ramp_duty == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

  localparam int unsigned R  = 4;
  localparam int unsigned DW = 4;

  typedef struct {
    int duty;
    int gap;   // cycles since previous duty change, 0 = don't care
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [R-1:0]  tgt_duty;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [R-1:0]  step;
  logic [DW-1:0] period_div;
  logic [R-1:0]  duty_cur;
  logic          pwm_out;
  logic          busy;
  logic          done;

  int   total  = 0;
  int   passed = 0;
  int   cycle  = 0;
  int   last_chg = 0;
  logic [R-1:0] prev_duty = '0;
  exp_t exp_q[$];

  pwm_ramp_ctrl #(.R(R), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tgt_duty   (tgt_duty),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .step       (step),
    .period_div (period_div),
    .duty_cur   (duty_cur),
    .pwm_out    (pwm_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push(input int d, input int g);
    exp_t e;
    e.duty = d;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  // One clock; samples 1 time unit after the edge and scores duty changes.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (duty_cur !== prev_duty) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_duty_change", 32'(duty_cur), 32'(prev_duty));
      end else begin
        e = exp_q.pop_front();
        chk("duty_step", 32'(duty_cur), 32'(e.duty));
        if (e.gap != 0) chk("update_spacing", 32'(cycle - last_chg), 32'(e.gap));
      end
      last_chg  = cycle;
      prev_duty = duty_cur;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    cycle++;
    reset     = 1'b0;
    tgt_valid = 1'b0;
    chk("rst_duty", 32'(duty_cur), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ready", 32'(tgt_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    prev_duty = '0;
  endtask

  task automatic xfer(input int t, input int s, input int d);
    tgt_duty   = R'(t);
    step       = R'(s);
    period_div = DW'(d);
    tgt_valid  = 1'b1;
    cyc();
    tgt_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input int tgt);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 1);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    chk({tag, "_final_duty"}, 32'(duty_cur), 32'(tgt));
    chk({tag, "_ready"}, 32'(tgt_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    cyc();
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic pwm_count(input string tag, input int exp_high);
    int hi = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (pwm_out === 1'b1) hi++;
    end
    chk(tag, 32'(hi), 32'(exp_high));
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    enable     = 1'b0;
    tgt_duty   = '0;
    tgt_valid  = 1'b0;
    step       = '0;
    period_div = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    enable = 1'b1;

    // Ramp up 0 -> 8 by 4, one update per period.
    push(4, 0);
    push(8, 16);
    xfer(8, 4, 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(tgt_ready), 0);
    wait_done("t1", 100, 8);
    pwm_count("t1_pwm_high", 8);

    // Ramp down 8 -> 1 by 5, every second period, last step clamped.
    push(3, 0);
    push(1, 32);
    xfer(1, 5, 1);
    chk("t2_busy", 32'(busy), 1);
    wait_done("t2", 200, 1);

    // Target equal to current duty: immediate done, no ramp.
    xfer(1, 3, 0);
    chk("t3_done", 32'(done), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_ready", 32'(tgt_ready), 1);
    cyc();
    chk("t3_done_pulse", 32'(done), 0);
    chk("t3_duty", 32'(duty_cur), 1);

    // Pause mid-ramp; targets offered during the ramp are ignored.
    push(3, 0);
    push(5, 0);
    push(7, 16);
    push(9, 16);
    xfer(9, 2, 0);
    n = 0;
    while (exp_q.size() > 3 && n < 40) begin
      cyc();
      n++;
    end
    chk("t5_first_update", 32'(exp_q.size()), 3);
    enable    = 1'b0;
    tgt_duty  = '0;
    tgt_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("t5_paused", {28'd0, pwm_out, busy, tgt_ready, (duty_cur === 4'd3)}, 32'b0101);
    end
    chk("t5_core_cnt", 32'(dut.u_core.cnt), 0);
    enable    = 1'b1;
    cyc();
    tgt_valid = 1'b0;
    wait_done("t5", 100, 9);

    // Fresh start, step 0 behaves as 1: fifteen updates up to full scale.
    do_reset();
    for (int d = 1; d <= 15; d++) push(d, (d == 1) ? 0 : 16);
    xfer(15, 0, 0);
    wait_done("t4", 400, 15);
    pwm_count("t4_pwm_high", 15);

    // Reset mid-ramp, coincident with an offered target.
    for (int d = 14; d >= 12; d--) push(d, (d == 14) ? 0 : 16);
    xfer(0, 1, 0);
    repeat (24) cyc();
    chk("t6_busy_before", 32'(busy), 1);
    tgt_duty  = 4'd5;
    tgt_valid = 1'b1;
    do_reset();
    cyc();
    chk("t6_idle_after", 32'(busy), 0);
    chk("t6_duty_after", 32'(duty_cur), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
